int_bitpacker: RTL and testbench

Sits directly downstream of the bfloat16-to-integer converter (fp2int_bfloat16). It consumes one signed quantized integer per valid cycle and packs each element's low `bitwidth` bits LSB-first into a dense stream of WORD_WIDTH-bit words for the memory writer. Elements may straddle word boundaries. A flush input closes a packet and emits any partial word zero-padded.

---
 rtl/int_bitpacker_pkg.sv | 15 +
 rtl/int_bitpacker_mask.sv | 24 ++
 rtl/int_bitpacker.sv | 125 ++++++++++++
 tb/tb_int_bitpacker.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/int_bitpacker_pkg.sv
// Shared defaults, state encoding and element-width clamp for the quantized-integer datapath
// (int_bitpacker and fp2int_bfloat16).
package int_bitpacker_pkg;

    localparam int unsigned MAX_BW_DEFAULT     = 16;
    localparam int unsigned WORD_WIDTH_DEFAULT = 32;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_TAIL  = 1'b1;

    function automatic int unsigned clamp_bw(input int unsigned bw, input int unsigned max_bw);
        return (bw > max_bw) ? max_bw : bw;
    endfunction

endpackage

// File: rtl/int_bitpacker_mask.sv
// Clamps the requested element width and keeps only that many LSBs of the element.
module int_bitpacker_mask
    import int_bitpacker_pkg::*;
#(
    parameter int unsigned MAX_BW = MAX_BW_DEFAULT
) (
    input  logic [$clog2(MAX_BW):0] bitwidth,
    input  logic [MAX_BW-1:0]       value,
    output logic [MAX_BW-1:0]       masked,
    output logic [$clog2(MAX_BW):0] bw
);

    int unsigned bw_int;

    always_comb begin
        bw_int = clamp_bw(int'(unsigned'(bitwidth)), MAX_BW);
        bw     = ($clog2(MAX_BW) + 1)'(bw_int);
        masked = '0;
        for (int unsigned i = 0; i < MAX_BW; i++) begin
            masked[i] = value[i] & (i < bw_int);
        end
    end

endmodule

// File: rtl/int_bitpacker.sv
// Packs variable-width quantized integers LSB-first into dense fixed-width words; a flush
// closes the packet and emits any partial word zero-padded.
module int_bitpacker
    import int_bitpacker_pkg::*;
#(
    parameter int unsigned MAX_BITWIDTH_QUANTIZED_DATA = MAX_BW_DEFAULT,
    parameter int unsigned WORD_WIDTH                  = WORD_WIDTH_DEFAULT
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         values_rdy,
    input  logic [$clog2(MAX_BITWIDTH_QUANTIZED_DATA):0] bitwidth,
    input  logic [MAX_BITWIDTH_QUANTIZED_DATA-1:0]       value,
    input  logic                                         flush,
    output logic                                         word_rdy,
    output logic [WORD_WIDTH-1:0]                        word,
    output logic                                         word_last,
    output logic [$clog2(WORD_WIDTH):0]                  word_valid_bits
);

    localparam int unsigned MAXW   = MAX_BITWIDTH_QUANTIZED_DATA;
    localparam int unsigned BW_W   = $clog2(MAXW) + 1;
    localparam int unsigned VB_W   = $clog2(WORD_WIDTH) + 1;
    localparam int unsigned ACC_W  = WORD_WIDTH + MAXW;
    localparam int unsigned FILL_W = $clog2(ACC_W + 1);
    localparam logic [FILL_W-1:0] WORD_FILL = FILL_W'(WORD_WIDTH);
    localparam logic [VB_W-1:0]   WORD_VB   = VB_W'(WORD_WIDTH);

    logic [MAXW-1:0]   masked;
    logic [BW_W-1:0]   bw_clamped;
    logic [BW_W-1:0]   bw_eff;
    logic [ACC_W-1:0]  ins_val;
    logic [ACC_W-1:0]  base_acc;
    logic [FILL_W-1:0] base_fill;
    logic [ACC_W-1:0]  acc_new;
    logic [FILL_W-1:0] nfill;

    logic [0:0]        state;
    logic [ACC_W-1:0]  acc;
    logic [FILL_W-1:0] fill;

    int_bitpacker_mask #(
        .MAX_BW (MAXW)
    ) u_mask (
        .bitwidth (bitwidth),
        .value    (value),
        .masked   (masked),
        .bw       (bw_clamped)
    );

    // In TAIL the held bits belong to the closing packet, so a new element starts from empty.
    always_comb begin
        bw_eff    = values_rdy ? bw_clamped : '0;
        ins_val   = values_rdy ? ACC_W'(masked) : '0;
        base_acc  = (state == ST_TAIL) ? '0 : acc;
        base_fill = (state == ST_TAIL) ? '0 : fill;
        acc_new   = base_acc | (ins_val << base_fill);
        nfill     = base_fill + FILL_W'(bw_eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_rdy        <= 1'b0;
            word            <= '0;
            word_last       <= 1'b0;
            word_valid_bits <= '0;
            acc             <= '0;
            fill            <= '0;
            state           <= ST_ACCUM;
        end else begin
            word_rdy <= 1'b0;
            if (state == ST_TAIL) begin
                word_rdy        <= 1'b1;
                word            <= acc[WORD_WIDTH-1:0];
                word_last       <= 1'b1;
                word_valid_bits <= VB_W'(fill);
                if (flush && (bw_eff != '0)) begin
                    // Output slot is taken by the remainder; the flushed element goes out next.
                    acc   <= acc_new;
                    fill  <= nfill;
                    state <= ST_TAIL;
                end else if (flush) begin
                    acc   <= '0;
                    fill  <= '0;
                    state <= ST_ACCUM;
                end else begin
                    acc   <= acc_new;
                    fill  <= nfill;
                    state <= ST_ACCUM;
                end
            end else if (flush) begin
                if (nfill == '0) begin
                    acc  <= '0;
                    fill <= '0;
                end else if (nfill <= WORD_FILL) begin
                    word_rdy        <= 1'b1;
                    word            <= acc_new[WORD_WIDTH-1:0];
                    word_last       <= 1'b1;
                    word_valid_bits <= VB_W'(nfill);
                    acc             <= '0;
                    fill            <= '0;
                end else begin
                    word_rdy        <= 1'b1;
                    word            <= acc_new[WORD_WIDTH-1:0];
                    word_last       <= 1'b0;
                    word_valid_bits <= WORD_VB;
                    acc             <= acc_new >> WORD_WIDTH;
                    fill            <= nfill - WORD_FILL;
                    state           <= ST_TAIL;
                end
            end else if (nfill >= WORD_FILL) begin
                word_rdy        <= 1'b1;
                word            <= acc_new[WORD_WIDTH-1:0];
                word_last       <= 1'b0;
                word_valid_bits <= WORD_VB;
                acc             <= acc_new >> WORD_WIDTH;
                fill            <= nfill - WORD_FILL;
            end else begin
                acc  <= acc_new;
                fill <= nfill;
            end
        end
    end

endmodule

// File: tb/tb_int_bitpacker.sv
// Directed bench for int_bitpacker: bit-queue reference model checked every cycle plus
// hand-computed word expectations.
module tb_int_bitpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic        values_rdy;
    logic [4:0]  bitwidth;
    logic [15:0] value;
    logic        flush;
    logic        word_rdy;
    logic [31:0] word;
    logic        word_last;
    logic [5:0]  word_valid_bits;

    always #5 clk = ~clk;

    int_bitpacker #(
        .MAX_BITWIDTH_QUANTIZED_DATA (16),
        .WORD_WIDTH                  (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .values_rdy      (values_rdy),
        .bitwidth        (bitwidth),
        .value           (value),
        .flush           (flush),
        .word_rdy        (word_rdy),
        .word            (word),
        .word_last       (word_last),
        .word_valid_bits (word_valid_bits)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the packet is a FIFO of bits; one output slot per cycle.
    logic        exp_rdy  = 1'b0;
    logic [31:0] exp_word = '0;
    logic        exp_last = 1'b0;
    logic [5:0]  exp_vb   = '0;
    bit          q[$];
    bit          def_v    = 1'b0;
    logic [31:0] def_word;
    int          def_bits;

    task automatic take(input int n, output logic [31:0] w);
        w = '0;
        for (int i = 0; i < n; i++) w[i] = q.pop_front();
    endtask

    task automatic emit(input logic [31:0] w, input bit l, input int n);
        exp_rdy  = 1'b1;
        exp_word = w;
        exp_last = l;
        exp_vb   = 6'(n);
    endtask

    task automatic model(input bit r, input bit vr, input int bwin, input logic [15:0] v,
                         input bit fl);
        int          bw;
        int          n;
        bit          slot_used;
        logic [31:0] w;
        exp_rdy = 1'b0;
        if (r) begin
            q.delete();
            def_v    = 1'b0;
            exp_word = '0;
            exp_last = 1'b0;
            exp_vb   = '0;
            return;
        end
        bw = (bwin > 16) ? 16 : bwin;
        if (!vr) bw = 0;
        slot_used = 1'b0;
        if (def_v) begin
            emit(def_word, 1'b1, def_bits);
            def_v     = 1'b0;
            slot_used = 1'b1;
            q.delete();
        end
        for (int i = 0; i < bw; i++) q.push_back(v[i]);
        if (fl) begin
            n = q.size();
            if (n == 0) begin
            end else if (slot_used) begin
                take(n, def_word);
                def_bits = n;
                def_v    = 1'b1;
            end else if (n <= 32) begin
                take(n, w);
                emit(w, 1'b1, n);
            end else begin
                take(32, w);
                emit(w, 1'b0, 32);
                def_bits = q.size();
                take(def_bits, def_word);
                def_v = 1'b1;
            end
        end else if (q.size() >= 32 && !slot_used) begin
            take(32, w);
            emit(w, 1'b0, 32);
        end
    endtask

    always @(posedge clk) begin
        #1;
        total++;
        if (word_rdy !== exp_rdy || word !== exp_word || word_last !== exp_last ||
            word_valid_bits !== exp_vb) begin
            bad++;
            $display("FAIL cycle_model t=%0t got rdy=%b word=%h last=%b vb=%0d want rdy=%b word=%h last=%b vb=%0d",
                     $time, word_rdy, word, word_last, word_valid_bits,
                     exp_rdy, exp_word, exp_last, exp_vb);
        end
    end

    task automatic step(input bit r, input bit vr, input int bwin, input logic [15:0] v,
                        input bit fl);
        @(negedge clk);
        rst        = r;
        values_rdy = vr;
        bitwidth   = 5'(bwin);
        value      = v;
        flush      = fl;
        model(r, vr, bwin, v, fl);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 16'h0, 1'b0);
    endtask

    task automatic lit(input string name, input bit r, input logic [31:0] w, input bit l,
                       input int vb);
        total++;
        if (word_rdy !== r || (r && (word !== w || word_last !== l || word_valid_bits !== 6'(vb))))
        begin
            bad++;
            $display("FAIL %s got rdy=%b word=%h last=%b vb=%0d want rdy=%b word=%h last=%b vb=%0d",
                     name, word_rdy, word, word_last, word_valid_bits, r, w, l, vb);
        end
    endtask

    initial begin
        rst = 1'b1; values_rdy = 1'b0; bitwidth = '0; value = '0; flush = 1'b0;
        step(1'b1, 1'b0, 0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 0, 16'h0, 1'b0);
        lit("reset", 1'b0, 32'h0, 1'b0, 0);
        total++;
        if (word !== 32'h0 || word_valid_bits !== 6'd0) begin
            bad++;
            $display("FAIL reset_word got %h/%0d want 0/0", word, word_valid_bits);
        end

        // Eight nibbles closed by flush on the last.
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 4, 16'(i), i == 8);
        lit("nibbles", 1'b1, 32'h87654321, 1'b1, 32);
        idle();
        lit("nibbles_no_second", 1'b0, 32'h0, 1'b0, 0);

        // Two full-width elements make one word.
        step(1'b0, 1'b1, 16, 16'hFFFF, 1'b0);
        lit("bw16_hold", 1'b0, 32'h0, 1'b0, 0);
        step(1'b0, 1'b1, 16, 16'h0001, 1'b0);
        lit("bw16_word", 1'b1, 32'h0001FFFF, 1'b0, 32);
        idle();
        step(1'b0, 1'b0, 0, 16'h0, 1'b1);
        lit("bw16_fill_zero", 1'b0, 32'h0, 1'b0, 0);

        // Straddling 12-bit elements, remainder flushed without an element.
        step(1'b0, 1'b1, 12, 16'h0ABC, 1'b0);
        step(1'b0, 1'b1, 12, 16'h0DEF, 1'b0);
        step(1'b0, 1'b1, 12, 16'h0123, 1'b0);
        lit("straddle_word", 1'b1, 32'h23DEFABC, 1'b0, 32);
        step(1'b0, 1'b0, 0, 16'h0, 1'b1);
        lit("straddle_rem", 1'b1, 32'h00000001, 1'b1, 4);

        // Sign bits above bw are discarded.
        step(1'b0, 1'b1, 4, 16'hFFFD, 1'b1);
        lit("sign_mask", 1'b1, 32'h0000000D, 1'b1, 4);

        // Width 20 clamps to 16.
        step(1'b0, 1'b1, 20, 16'h1234, 1'b0);
        step(1'b0, 1'b1, 20, 16'h5678, 1'b0);
        lit("clamp", 1'b1, 32'h56781234, 1'b0, 32);

        // Zero-width elements are dropped; their flush still closes the packet.
        step(1'b0, 1'b1, 0, 16'hFFFF, 1'b1);
        lit("bw0_empty", 1'b0, 32'h0, 1'b0, 0);
        step(1'b0, 1'b1, 4, 16'h0005, 1'b0);
        step(1'b0, 1'b1, 0, 16'hFFFF, 1'b1);
        lit("bw0_flush", 1'b1, 32'h00000005, 1'b1, 4);

        // Flush overflow into TAIL, with a new flushed element during TAIL.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4, 16'h000F, 1'b0);
        step(1'b0, 1'b1, 8, 16'h00A5, 1'b1);
        lit("tail_low", 1'b1, 32'h5FFFFFFF, 1'b0, 32);
        step(1'b0, 1'b1, 4, 16'h0003, 1'b1);
        lit("tail_rem", 1'b1, 32'h0000000A, 1'b1, 4);
        idle();
        lit("tail_next_pkt", 1'b1, 32'h00000003, 1'b1, 4);
        idle();
        lit("tail_quiet", 1'b0, 32'h0, 1'b0, 0);

        // Reset mid-packet discards held bits.
        step(1'b0, 1'b1, 8, 16'h00AA, 1'b0);
        step(1'b0, 1'b1, 8, 16'h00BB, 1'b0);
        step(1'b0, 1'b1, 8, 16'h00CC, 1'b0);
        step(1'b1, 1'b0, 0, 16'h0, 1'b0);
        total++;
        if (word_rdy !== 1'b0 || word !== 32'h0 || word_last !== 1'b0 || word_valid_bits !== 6'd0)
        begin
            bad++;
            $display("FAIL mid_reset got rdy=%b word=%h last=%b vb=%0d want all 0",
                     word_rdy, word, word_last, word_valid_bits);
        end
        step(1'b0, 1'b1, 8, 16'h0011, 1'b1);
        lit("post_reset", 1'b1, 32'h00000011, 1'b1, 8);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
